// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the CPU control path. Produces the
//   instruction fetch address and supports stall, absolute load, relative
//   branch, skip, and subroutine call/return through a small internal
//   return-address stack. All PC arithmetic wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH        PC / address width in bits
//   STACK_DEPTH  number of return-address stack entries (>= 1)
//   RESET_ADDR   PC value loaded on reset
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   EN        in   advance enable; 0 stalls PC and stack
//   WE        in   direct PC load from data_in; overrides EN and op
//   data_in   in   direct-load value
//   op        in   0 INC, 1 JMP, 2 BRR, 3 SKIP, 4 CALL, 5 RET, 6/7 act as INC
//   target    in   JMP/CALL absolute address, BRR signed offset
//   err_clr   in   clears the sticky error flags
//   data_out  out  current PC (registered)
//   ret_addr  out  top-of-stack entry, 0 when the stack is empty
//   sp        out  number of valid stack entries (registered)
//   full      out  sp == STACK_DEPTH
//   empty     out  sp == 0
//   err_ovf   out  sticky: CALL attempted while full
//   err_unf   out  sticky: RET attempted while empty
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               EN,
  input  logic                               WE,
  input  logic [WIDTH-1:0]                   data_in,
  input  logic [2:0]                         op,
  input  logic [WIDTH-1:0]                   target,
  input  logic                               err_clr,
  output logic [WIDTH-1:0]                   data_out,
  output logic [WIDTH-1:0]                   ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               full,
  output logic                               empty,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRR  = 3'd2,
    OP_SKIP = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] top_entry;
  logic [SPW-1:0]   sp_nxt;
  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  top_idx;
  logic             push;
  logic             ovf_set;
  logic             unf_set;

  // ---------------------------------------------------------------------
  // Stack view
  // ---------------------------------------------------------------------
  assign full    = (sp == SPW'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IDXW'(sp);
  assign top_idx = IDXW'(sp - SPW'(1));

  assign top_entry = stack_mem[top_idx];
  assign ret_addr  = empty ? '0 : top_entry;

  assign pc_inc = data_out + WIDTH'(1);

  // ---------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------
  always_comb begin
    pc_nxt  = data_out;
    sp_nxt  = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (WE) begin
      pc_nxt = data_in;
    end else if (EN) begin
      case (op)
        OP_JMP:  pc_nxt = target;
        // Same-width add is the sign-extended add modulo 2^WIDTH.
        OP_BRR:  pc_nxt = data_out + target;
        OP_SKIP: pc_nxt = data_out + WIDTH'(2);
        OP_CALL: begin
          if (full) begin
            pc_nxt  = pc_inc;
            ovf_set = 1'b1;
          end else begin
            pc_nxt = target;
            sp_nxt = sp + SPW'(1);
            push   = 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_nxt  = pc_inc;
            unf_set = 1'b1;
          end else begin
            pc_nxt = top_entry;
            sp_nxt = sp - SPW'(1);
          end
        end
        default: pc_nxt = pc_inc;   // INC and the unused codes 6/7
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= RESET_ADDR;
      sp       <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      data_out <= pc_nxt;
      sp       <= sp_nxt;
      // A new error event in the same cycle as err_clr leaves the flag set.
      err_ovf  <= ovf_set | (err_ovf & ~err_clr);
      err_unf  <= unf_set | (err_unf & ~err_clr);
    end
  end

  // Stack RAM has no reset. A write racing a reset edge is harmless since
  // sp returns to 0 and the entry is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

endmodule
